div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
- Sits in the EX stage beside the single-cycle ALU. The ALU covers the forward arithmetic (add/sub/shift); this block covers division and remainder.
- Hazard logic stalls the pipeline while o_busy is high. The result is captured when o_valid pulses.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous active-high reset
i_start  input  1  request new operation; accepted only in IDLE
i_flush  input  1  abort current operation (branch mispredict / trap)
i_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_operand_a  input  32  dividend (rs1)
i_operand_b  input  32  divisor (rs2)
o_busy  output  1  high in every state except IDLE
o_valid  output  1  one-cycle pulse: o_result is new
o_result  output  32  quotient or remainder; holds until next completion

Behaviour:
- Clock, reset and polarity: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_result=0, counter=0, internal quotient/remainder registers=0.
- States: IDLE, CALC, FIX.
- IDLE, i_start=1, no special case:
  - Latch op and signedness (signed = op[0]==0).
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch neg_q = signed & (a[31]^b[31]) & (b!=0), and neg_r = signed & a[31].
  - Clear partial remainder, clear counter, go to CALC.
- CALC, one quotient bit per cycle:
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left.
  - If rem' >= divisor (33-bit unsigned compare): rem = rem' - divisor and shift in quotient bit 1; else rem = rem' and shift in 0.
  - After 32 CALC cycles (counter==31 at the edge) go to FIX.
- FIX:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select quotient for op[1]==0, remainder for op[1]==1.
  - Register the selection into o_result, set o_valid=1, go to IDLE.
- Latency, normal path: start accepted at edge k -> o_valid high in the cycle after edge k+33 (34 cycles). o_busy is high from edge k+1 through edge k+33, i.e. it is low in the o_valid cycle.
- Special cases resolve at the accepting edge: o_result is registered directly, o_valid=1 next cycle, state stays IDLE, o_busy never rises.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- o_valid is never high for two consecutive cycles unless a new start was accepted in the o_valid cycle itself. IDLE accepts i_start in the same cycle o_valid is high.
- i_start in CALC or FIX: ignored, no effect on the operation in flight.
- i_flush:
  - Any state -> IDLE at the next edge; o_valid=0 that cycle; o_result unchanged.
  - Flush and start in the same cycle: flush wins, start is dropped.
  - Flush in the FIX cycle: the result is discarded (no o_valid).
- i_reset mid-operation: all registers return to reset values at the next edge; no o_valid. Reset has priority over flush and start.
- Operands are sampled only at the accepting edge. Input changes afterwards do not affect the result.
- Arithmetic: internal partial remainder is 33 bits; all subtract/compare is unsigned on magnitudes. Negating 0x80000000 yields 0x80000000, with magnitude handled as unsigned 2^31.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> o_valid exactly 34 cycles after start, o_result=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=0x10 -> 0x0FFFFFFF. REMU on the same operands -> 0xF. o_busy high 33 cycles, low during the o_valid cycle.
- Divide by zero: DIV a=0x1234, b=0 -> 0xFFFFFFFF. REM a=0x1234, b=0 -> 0x1234. Both with o_valid 1 cycle after start and o_busy never high.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0. Both 1-cycle latency.
- Flush at CALC cycle 10, then new DIVU 100/7 started 2 cycles later -> no o_valid from the aborted op; o_result=14 after 34 cycles. Start pulsed during CALC is ignored.
- Reset asserted at CALC cycle 20 -> next cycle o_busy=0, o_valid=0, o_result=0. A back-to-back start in the o_valid cycle is accepted and completes 34 cycles later.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow resolve at once.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [1:0]      i_div_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   dvd;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic              op_rem;
  logic              neg_q;
  logic              neg_r;

  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_sub;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  // Operand conditioning, one restoring step, and final sign fix-up.
  always_comb begin
    is_signed = ~i_div_op[0];
    a_neg     = is_signed & i_operand_a[XLEN-1];
    b_neg     = is_signed & i_operand_b[XLEN-1];
    abs_a     = a_neg ? -i_operand_a : i_operand_a;
    abs_b     = b_neg ? -i_operand_b : i_operand_b;
    div0      = (i_operand_b == '0);
    ovf       = is_signed
              & (i_operand_a == {1'b1, {(XLEN-1){1'b0}}})
              & (i_operand_b == '1);
    spec_res  = '0;
    if (div0) begin
      spec_res = i_div_op[1] ? i_operand_a : '1;
    end else begin
      spec_res = i_div_op[1] ? '0 : i_operand_a;
    end
    rem_sh  = {rem, dvd[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[XLEN-1:0] - dvs;
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
  end

  // Control FSM with registered busy/valid/result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            if (div0 || ovf) begin
              o_result <= spec_res;
              o_valid  <= 1'b1;
            end else begin
              op_rem <= i_div_op[1];
              dvd    <= abs_a;
              dvs    <= abs_b;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              rem    <= '0;
              quo    <= '0;
              cnt    <= '0;
              o_busy <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[XLEN-2:0], 1'b0};
          quo <= {quo[XLEN-2:0], ge};
          rem <= ge ? rem_sub : rem_sh[XLEN-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == {CNT_W{1'b1}}) begin
            state <= FIX;
          end
        end
        FIX: begin
          o_result <= op_rem ? r_fix : q_fix;
          o_valid  <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Random ops against an arithmetic reference plus directed corner cases.
module tb_div_unit;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic        i_flush;
  logic [1:0]  i_div_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int n_tests;
  int n_fail;

  div_unit dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_flush     (i_flush),
    .i_div_op    (i_div_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_result    (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa;
    int  sb;
    bit  ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return ovf ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Caller sits at a negedge; the next posedge accepts the start.
  task automatic launch(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int poke,
                        output logic [31:0] res,
                        output int lat,
                        output int busy_n);
    bit done;
    i_start     = 1'b1;
    i_div_op    = op;
    i_operand_a = a;
    i_operand_b = b;
    lat    = 0;
    busy_n = 0;
    done   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      i_start     = (lat == poke);
      i_div_op    = 2'($urandom);
      i_operand_a = $urandom;
      i_operand_b = $urandom;
      @(negedge clk);
      if (o_valid) begin
        done = 1;
        check("busy_in_valid", 32'(o_busy), 32'd0);
      end else if (o_busy) begin
        busy_n++;
      end
    end
    i_start = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
    res = o_result;
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int poke,
                       output logic [31:0] res,
                       output int lat,
                       output int busy_n);
    @(negedge clk);
    launch(op, a, b, poke, res, lat, busy_n);
  endtask

  task automatic op_checked(input string tag,
                            input logic [1:0] op,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input int poke);
    logic [31:0] res;
    int lat;
    int bn;
    bit sp;
    sp = is_special(op, a, b);
    do_op(op, a, b, poke, res, lat, bn);
    check({tag, "_res"}, res, ref_div(op, a, b));
    check({tag, "_lat"}, 32'(lat), sp ? 32'd1 : 32'd34);
    check({tag, "_busy"}, 32'(bn), sp ? 32'd0 : 32'd33);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int lat;
    int bn;
    n_tests     = 0;
    n_fail      = 0;
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_flush     = 1'b0;
    i_div_op    = 2'd0;
    i_operand_a = '0;
    i_operand_b = '0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);

    op_checked("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    op_checked("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    op_checked("divu_big", 2'd1, 32'hFFFF_FFFF, 32'h10, 0);
    op_checked("remu_big", 2'd3, 32'hFFFF_FFFF, 32'h10, 0);
    op_checked("div_by0", 2'd0, 32'h1234, 32'd0, 0);
    op_checked("rem_by0", 2'd2, 32'h1234, 32'd0, 0);
    op_checked("divu_by0", 2'd1, 32'h8765_4321, 32'd0, 0);
    op_checked("remu_by0", 2'd3, 32'h8765_4321, 32'd0, 0);
    op_checked("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op_checked("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op_checked("divu_min", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op_checked("div_min_2", 2'd0, 32'h8000_0000, 32'd2, 0);
    op_checked("rem_neg_b", 2'd2, 32'd7, 32'hFFFF_FFFE, 0);

    // Flush mid-CALC, with a same-cycle start that must be dropped.
    prev = o_result;
    @(negedge clk);
    i_start     = 1'b1;
    i_div_op    = 2'd1;
    i_operand_a = 32'hFFFF_FFFF;
    i_operand_b = 32'd3;
    @(posedge clk);
    #1 i_start = 1'b0;
    bn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_valid) bn++;
    end
    check("flush_pre_valid", 32'(bn), 32'd0);
    i_flush     = 1'b1;
    i_start     = 1'b1;
    i_operand_b = 32'd1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(o_busy), 32'd0);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_result", o_result, prev);
    bn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_valid || o_busy) bn++;
    end
    check("flush_quiet", 32'(bn), 32'd0);

    // Start pulsed during CALC must not disturb the op in flight.
    op_checked("divu_100_7", 2'd1, 32'd100, 32'd7, 10);

    // Reset mid-operation.
    @(negedge clk);
    i_start     = 1'b1;
    i_div_op    = 2'd0;
    i_operand_a = 32'd12345;
    i_operand_b = 32'd17;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (20) @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_result", o_result, 32'd0);

    // Back-to-back start in the o_valid cycle.
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bn);
    check("b2b_first", res, 32'hFFFF_FFFD);
    launch(2'd2, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bn);
    check("b2b_res", res, 32'hFFFF_FFFF);
    check("b2b_lat", 32'(lat), 32'd34);

    // Randomized sweep with occasional corner operands.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: b = -$urandom_range(1, 16);
        default: ;
      endcase
      op_checked("rand", op, a, b, $urandom_range(0, 40));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
